cmp_scheduler: RTL and testbench
================================

CMP_SCHEDULER -- requirements
Module: cmp_scheduler

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing one comparator.
REQ-002 SHALL have parameter width, default 36; operands are [width:0] (37-bit FP 11_23: [36:35] exception, [34] sign, [33:23] exponent, [22:0] mantissa).
REQ-003 SHALL have parameter LAT, default 3; comparator latency in cycles from cmp_a/cmp_b presented to cmp_le valid.
REQ-004 SHALL have ports, one per line:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester operand-pair valid.
- req_a  in  N_REQ*(width+1)  packed operand A; slice i is requester i.
- req_b  in  N_REQ*(width+1)  packed operand B; slice i is requester i.
- req_ready  out  N_REQ  one-hot-or-zero accept.
- cmp_a  out  width+1  operand A to the shared comparator.
- cmp_b  out  width+1  operand B to the shared comparator.
- cmp_le  in  1  comparator result, A<=B.
- res_valid  out  N_REQ  one-cycle result strobe, one-hot-or-zero.
- res_le  out  1  delivered A<=B result.
- res_unord  out  1  delivered unordered flag.
- busy  out  1  any comparison in flight.

Function
REQ-005 Arbitration SHALL be round-robin: grant = lowest index i, searching upward from rr_ptr with wrap, such that req_valid[i]=1 and pending[i]=0.
REQ-006 req_ready SHALL be combinational, asserted only at the granted index; all zero when no eligible requester exists.
REQ-007 Issue SHALL occur on a clock edge where req_valid[g]&req_ready[g]=1; at most one issue per cycle.
REQ-008 On issue: cmp_a/cmp_b SHALL register slice g of req_a/req_b; pending[g] set; rr_ptr <= (g+1) mod N_REQ.
REQ-009 With no issue, cmp_a/cmp_b and rr_ptr SHALL hold.
REQ-010 Each requester SHALL have at most one comparison in flight; pending[i] blocks req_ready[i].
REQ-011 A tag pipeline of depth LAT+1 SHALL carry {valid, index, unord} alongside each issued pair; unord = (A[36:35]==2'b11)|(B[36:35]==2'b11).
REQ-012 Result delivery SHALL register cmp_le into res_le when the tag reaches the pipeline end; res_valid[index] is high exactly one cycle, LAT+2 edges after the issue edge.
REQ-013 When unord=1, res_le SHALL be 0 and res_unord SHALL be 1; otherwise res_unord SHALL be 0 and res_le SHALL equal cmp_le.
REQ-014 pending[index] SHALL clear on the delivery edge; same-cycle re-issue by that requester SHALL NOT occur (earliest re-issue is the next edge).
REQ-015 Throughput SHALL be one issue per cycle when distinct requesters are eligible; back-to-back results SHALL be delivered in issue order.
REQ-016 busy SHALL equal the OR of all tag-pipeline valid bits and all pending bits.
REQ-017 res_le and res_unord SHALL hold their last values when res_valid is zero.

Reset
REQ-018 When rst=1 at a clock edge, all of the following SHALL be 0 after that edge: rr_ptr, pending, tag pipeline, cmp_a, cmp_b, res_valid, res_le, res_unord, busy.
REQ-019 req_ready SHALL be all zero while rst=1.
REQ-020 Comparisons in flight at reset SHALL be discarded; no res_valid SHALL appear for them after reset deasserts.

Verification
REQ-021 Single request: LAT=3; requester 2 issues A=1.0, B=2.0 (exception 01, exponents 0x3FF/0x400). Required: res_valid=4'b0100 exactly 5 edges after issue; res_le=1; res_unord=0.
REQ-022 All four requesters valid continuously from reset. Required: grants 0,1,2,3 on consecutive cycles; requester 0 is not re-granted before its result is delivered; results arrive in order 0,1,2,3.
REQ-023 Unordered case: requester 1 issues A=NaN (exception 11), B=1.0. Required: res_valid[1]=1, res_le=0, res_unord=1, regardless of the cmp_le value.
REQ-024 Wrap: rr_ptr=3; requesters 0 and 3 valid. Required: grant 3 first, then 0, with rr_ptr=1 afterwards.
REQ-025 Reset mid-flight: issue on requesters 0 and 1, then assert rst for 1 cycle at issue+2. Required: no res_valid for 10 cycles, busy=0, and the next grant goes to requester 0.
REQ-026 Equal operands: A=B=-0.5. Required: res_le=1, and busy falls the cycle after res_valid.

Source files
------------

// File: rtl/cmp_scheduler.sv
// cmp_scheduler: round-robin sharing of one pipelined FP comparator among
// N_REQ requesters. Each requester may have one comparison in flight; results
// return in issue order with an unordered (NaN) flag.
module cmp_scheduler #(
  parameter int N_REQ = 4,
  parameter int width = 36,
  parameter int LAT   = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*(width+1)-1:0] req_a,
  input  logic [N_REQ*(width+1)-1:0] req_b,
  output logic [N_REQ-1:0]           req_ready,
  output logic [width:0]             cmp_a,
  output logic [width:0]             cmp_b,
  input  logic                       cmp_le,
  output logic [N_REQ-1:0]           res_valid,
  output logic                       res_le,
  output logic                       res_unord,
  output logic                       busy
);

  localparam int OW = width + 1;
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Exception field 2'b11 marks NaN in the 11_23 format.
  function automatic logic is_nan(input logic [width:0] v);
    return (v[width -: 2] == 2'b11);
  endfunction

  logic [IW-1:0]    rr_ptr;
  logic [N_REQ-1:0] pending;
  logic [N_REQ-1:0] pending_next;
  logic [N_REQ-1:0] res_onehot;
  logic             grant_vld;
  logic [IW-1:0]    grant_idx;
  logic [IW-1:0]    ptr_next;
  logic [width:0]   sel_a;
  logic [width:0]   sel_b;

  // issue stage: tag travelling with cmp_a/cmp_b
  logic             vld_p0;
  logic [IW-1:0]    idx_p0;
  logic             unord_p0;

  // tag chain: aligned with the comparator's internal stages
  logic [LAT:0]     vld_p1;
  logic [IW-1:0]    idx_p1   [LAT+1];
  logic             unord_p1 [LAT+1];

  // Round-robin search from rr_ptr for a valid requester with nothing in flight
  always_comb begin
    logic [IW-1:0] cand;
    int            j;
    grant_vld = 1'b0;
    grant_idx = '0;
    req_ready = '0;
    sel_a     = '0;
    sel_b     = '0;
    cand      = '0;
    j         = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      cand = IW'(j);
      if (!rst && !grant_vld && req_valid[cand] && !pending[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    if (grant_vld) req_ready[grant_idx] = 1'b1;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_idx == IW'(k)) begin
        sel_a = req_a[k*OW +: OW];
        sel_b = req_b[k*OW +: OW];
      end
    end
    ptr_next = (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  // In-flight bookkeeping: delivery frees a requester, issue occupies one
  always_comb begin
    pending_next = pending;
    res_onehot   = '0;
    if (vld_p1[LAT]) begin
      pending_next[idx_p1[LAT]] = 1'b0;
      res_onehot[idx_p1[LAT]]   = 1'b1;
    end
    if (grant_vld) pending_next[grant_idx] = 1'b1;
  end

  // ---- stage p0: issue the granted pair to the comparator ----
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      pending  <= '0;
      cmp_a    <= '0;
      cmp_b    <= '0;
      vld_p0   <= 1'b0;
      idx_p0   <= '0;
      unord_p0 <= 1'b0;
    end else begin
      vld_p0  <= grant_vld;
      pending <= pending_next;
      if (grant_vld) begin
        cmp_a    <= sel_a;
        cmp_b    <= sel_b;
        idx_p0   <= grant_idx;
        unord_p0 <= is_nan(sel_a) | is_nan(sel_b);
        rr_ptr   <= ptr_next;
      end
    end
  end

  // ---- stage p1: tag chain shadowing the comparator latency ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= '0;
      for (int k = 0; k <= LAT; k++) begin
        idx_p1[k]   <= '0;
        unord_p1[k] <= 1'b0;
      end
    end else begin
      vld_p1[0]   <= vld_p0;
      idx_p1[0]   <= idx_p0;
      unord_p1[0] <= unord_p0;
      for (int k = 1; k <= LAT; k++) begin
        vld_p1[k]   <= vld_p1[k-1];
        idx_p1[k]   <= idx_p1[k-1];
        unord_p1[k] <= unord_p1[k-1];
      end
    end
  end

  // ---- stage p2: deliver result, forcing le low for unordered pairs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= '0;
      res_le    <= 1'b0;
      res_unord <= 1'b0;
      busy      <= 1'b0;
    end else begin
      res_valid <= res_onehot;
      if (vld_p1[LAT]) begin
        res_le    <= cmp_le & ~unord_p1[LAT];
        res_unord <= unord_p1[LAT];
      end
      busy <= vld_p0 | (|vld_p1) | (|pending);
    end
  end

endmodule

// File: tb/tb_cmp_scheduler.sv
// Bench for cmp_scheduler: random and directed traffic, a comparator model in
// the environment, a reference model of arbitration/result timing and a
// scoreboard monitor on the result port.
module tb_cmp_scheduler;

  localparam int N   = 4;
  localparam int W   = 36;
  localparam int LAT = 3;
  localparam int OW  = W + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*OW-1:0] req_a = '0;
  logic [N*OW-1:0] req_b = '0;
  logic [N-1:0]    req_ready;
  logic [W:0]      cmp_a;
  logic [W:0]      cmp_b;
  logic            cmp_le;
  logic [N-1:0]    res_valid;
  logic            res_le;
  logic            res_unord;
  logic            busy;

  cmp_scheduler #(.N_REQ(N), .width(W), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_le(cmp_le),
    .res_valid(res_valid), .res_le(res_le), .res_unord(res_unord), .busy(busy)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (edge %0d)", name, act, exp, cyc);
    end
  endfunction

  // Total order of 11_23 values: zero (either sign) < normals ordered by
  // exponent/mantissa < infinity, negated for sign.
  function automatic longint fp_key(logic [OW-1:0] v);
    longint m;
    case (v[36:35])
      2'b00:   m = 0;
      2'b01:   m = longint'(v[33:0]) + 1;
      2'b10:   m = longint'(1) << 40;
      default: m = 0;
    endcase
    return v[34] ? -m : m;
  endfunction

  function automatic logic [OW-1:0] mk(logic [1:0] e, logic s, logic [10:0] x, logic [22:0] m);
    return {e, s, x, m};
  endfunction

  // External comparator: captures its inputs one edge after issue, result
  // valid LAT edges later.
  logic [LAT:0] le_pipe = '0;
  always @(posedge clk) le_pipe <= {le_pipe[LAT-1:0], (fp_key(cmp_a) <= fp_key(cmp_b))};
  assign cmp_le = le_pipe[LAT];

  typedef struct {
    int     idx;
    bit     le;
    bit     unord;
    longint issue;
    longint due;
  } exp_t;
  exp_t q[$];

  // Reference model: round-robin over eligible requesters, one in flight each
  int     rr_m = 0;
  bit     pend_m [N];
  longint pdue_m [N];

  always begin
    longint c;
    int     g;
    int     j;
    logic [N-1:0] exp_rdy;
    exp_t   e;
    @(negedge clk);
    #1;
    c = cyc;
    if (rst) begin
      chk("ready_in_reset", 64'(req_ready), 64'(0));
      for (int k = q.size() - 1; k >= 0; k--)
        if (q[k].due > c) q.delete(k);
      rr_m = 0;
      for (int i = 0; i < N; i++) pend_m[i] = 0;
    end else begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        j = (rr_m + k) % N;
        if (g < 0 && req_valid[j] && !pend_m[j]) g = j;
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      for (int i = 0; i < N; i++)
        if (pend_m[i] && pdue_m[i] == c + 1) pend_m[i] = 0;
      if (g >= 0) begin
        e.idx   = g;
        e.unord = (req_a[g*OW+35 +: 2] == 2'b11) || (req_b[g*OW+35 +: 2] == 2'b11);
        e.le    = !e.unord && (fp_key(req_a[g*OW +: OW]) <= fp_key(req_b[g*OW +: OW]));
        e.issue = c + 1;
        e.due   = c + 1 + LAT + 2;
        q.push_back(e);
        pend_m[g] = 1;
        pdue_m[g] = e.due;
        rr_m      = (g + 1) % N;
      end
    end
  end

  // Monitor: compares result port and busy against the scoreboard queue
  bit rst_q    = 1'b1;
  bit last_le  = 1'b0;
  bit last_uno = 1'b0;
  always @(negedge clk) begin
    longint c;
    bit     bexp;
    logic [N-1:0] oh;
    c = cyc;
    if (rst_q) begin
      chk("rst_res_valid", 64'(res_valid), 64'(0));
      chk("rst_res_le", 64'(res_le), 64'(0));
      chk("rst_res_unord", 64'(res_unord), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      last_le  = 0;
      last_uno = 0;
    end else begin
      bexp = 0;
      foreach (q[k]) if (q[k].issue < c) bexp = 1;
      chk("busy", 64'(busy), 64'(bexp));
      if (q.size() > 0 && q[0].due == c) begin
        oh = '0;
        oh[q[0].idx] = 1'b1;
        chk("res_valid", 64'(res_valid), 64'(oh));
        chk("res_le", 64'(res_le), 64'(q[0].le));
        chk("res_unord", 64'(res_unord), 64'(q[0].unord));
        last_le  = q[0].le;
        last_uno = q[0].unord;
        void'(q.pop_front());
      end else begin
        chk("res_valid_idle", 64'(res_valid), 64'(0));
        chk("res_le_hold", 64'(res_le), 64'(last_le));
        chk("res_unord_hold", 64'(res_unord), 64'(last_uno));
      end
    end
    rst_q = rst;
  end

  // Driver
  logic [N-1:0]  vld_d = '0;
  logic [OW-1:0] a_d [N];
  logic [OW-1:0] b_d [N];

  task automatic apply();
    req_valid = vld_d;
    for (int i = 0; i < N; i++) begin
      req_a[i*OW +: OW] = a_d[i];
      req_b[i*OW +: OW] = b_d[i];
    end
  endtask

  task automatic offer(int i, logic [OW-1:0] a, logic [OW-1:0] b);
    vld_d[i] = 1'b1;
    a_d[i]   = a;
    b_d[i]   = b;
    apply();
  endtask

  task automatic tick();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    vld_d = vld_d & ~acc;
    apply();
  endtask

  function automatic logic [OW-1:0] rnd_fp();
    int sel;
    logic [1:0] e;
    sel = $urandom_range(0, 9);
    e = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b10 : (sel == 2) ? 2'b11 : 2'b01;
    return mk(e, 1'($urandom_range(0, 1)), 11'(11'h3FC + $urandom_range(0, 7)),
              23'($urandom_range(0, 3)) << 20);
  endfunction

  localparam logic [OW-1:0] ONE   = {2'b01, 1'b0, 11'h3FF, 23'h0};
  localparam logic [OW-1:0] TWO   = {2'b01, 1'b0, 11'h400, 23'h0};
  localparam logic [OW-1:0] MHALF = {2'b01, 1'b1, 11'h3FE, 23'h0};
  localparam logic [OW-1:0] QNAN  = {2'b11, 1'b0, 11'h000, 23'h0};

  initial begin
    for (int i = 0; i < N; i++) begin
      a_d[i] = '0;
      b_d[i] = '0;
      pend_m[i] = 0;
      pdue_m[i] = 0;
    end
    apply();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    // single request, 1.0 <= 2.0
    offer(2, ONE, TWO);
    repeat (10) tick();
    // unordered pair
    offer(1, QNAN, ONE);
    repeat (10) tick();
    // equal operands
    offer(0, MHALF, MHALF);
    repeat (10) tick();
    // all requesters continuously valid
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) if (!vld_d[i]) offer(i, rnd_fp(), rnd_fp());
      tick();
    end
    vld_d = '0;
    apply();
    repeat (12) tick();
    // wrap: move pointer to 3, then contend 0 and 3
    offer(2, TWO, ONE);
    repeat (10) tick();
    offer(0, ONE, ONE);
    offer(3, TWO, MHALF);
    repeat (12) tick();
    // reset while two comparisons are in flight
    offer(0, ONE, TWO);
    offer(1, TWO, ONE);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    offer(0, MHALF, ONE);
    offer(1, ONE, MHALF);
    repeat (12) tick();
    // random traffic with occasional reset
    for (int t = 0; t < 600; t++) begin
      for (int i = 0; i < N; i++)
        if (!vld_d[i] && $urandom_range(0, 1) == 1) offer(i, rnd_fp(), rnd_fp());
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    vld_d = '0;
    apply();
    repeat (20) tick();
    chk("drained", 64'(q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
